dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter WIDTH, 32, data and address width in bits.
REQ-002 Parameter STARVE_MAX, 4, consecutive denied cycles after which the external requester is forced through; legal range 1..15.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 cpu_req_i  in  1  pipeline memory-stage access request; held until cpu_stall_o is low.
REQ-006 cpu_we_i  in  1  1 = store, 0 = load.
REQ-007 cpu_adr_i, cpu_wdata_i  in  WIDTH each  pipeline address and store data.
REQ-008 cpu_stall_o  out  1  freezes the pipeline while the CPU access is incomplete.
REQ-009 cpu_rdata_o  out  WIDTH  registered load data.
REQ-010 ext_req_i, ext_we_i  in  1 each  external (loader/debug) request and write flag; valid/ready semantics.
REQ-011 ext_adr_i, ext_wdata_i  in  WIDTH each  external address and write data.
REQ-012 ext_gnt_o  out  1  ready; the transfer completes in a cycle where ext_req_i and ext_gnt_o are both high.
REQ-013 ext_rdata_o  out  WIDTH, ext_rvalid_o  out  1  registered external read response.
REQ-014 ram_adr_o, ram_wdata_o  out  WIDTH each, ram_we_o  out  1  single-port data RAM drive; RAM read data is combinational on ram_rdata_i (in, WIDTH).

Function
REQ-015 At most one requester SHALL be granted per cycle; the granted requester's address, write data and write flag SHALL drive the ram_* outputs combinationally.
REQ-016 When neither requester is granted, ram_we_o SHALL be 0, and ram_adr_o and ram_wdata_o SHALL be 0.
REQ-017 Priority: the CPU SHALL win, except when starve_cnt == STARVE_MAX and ext_req_i is high, in which case the external requester SHALL win.
REQ-018 starve_cnt (4-bit) SHALL increment, saturating at STARVE_MAX, in each cycle where ext_req_i is high and ext_gnt_o is low; it SHALL clear on an external grant or when ext_req_i is low.
REQ-019 Response FSM states: IDLE, CPU_RSP, EXT_RSP.
- A granted read SHALL move the FSM to CPU_RSP or EXT_RSP; it returns to IDLE next cycle unless another read is granted in that cycle.
- ram_rdata_i SHALL be captured at the edge ending the grant cycle.
REQ-020 Read latency SHALL be 1 cycle: cpu_rdata_o and ext_rdata_o SHALL be valid in the cycle after the grant.
- ext_rvalid_o SHALL be high in EXT_RSP only.
- cpu_rdata_o SHALL hold its value until the next CPU read.
REQ-021 Writes SHALL complete in the grant cycle and SHALL NOT enter CPU_RSP or EXT_RSP.
REQ-022 cpu_stall_o SHALL equal cpu_req_i AND NOT (CPU write granted this cycle OR FSM == CPU_RSP).
- A CPU load therefore stalls exactly 1 cycle minimum.
- A CPU store stalls 0 cycles when granted.
REQ-023 The CPU SHALL NOT be granted while FSM == CPU_RSP, so a held load is never re-issued; the external requester may be granted in that cycle.
REQ-024 Back-to-back grants SHALL be permitted: a grant may occur in a CPU_RSP or EXT_RSP cycle.
REQ-025 Reads and writes to the same address in adjacent cycles SHALL observe program order of grants; there is no internal buffering.

Reset
REQ-026 On rst_n low, asynchronously:
- FSM SHALL go to IDLE and starve_cnt to 0.
- cpu_rdata_o and ext_rdata_o SHALL go to 0, and ext_rvalid_o to 0.
- ext_gnt_o and ram_we_o SHALL be 0 while rst_n is low.
REQ-027 A read in flight at reset SHALL be discarded; no rvalid SHALL follow reset release.
REQ-028 The first grant SHALL be possible in the first cycle after rst_n deasserts.

Verification
REQ-029 CPU load of adr 0x10 (RAM holds 0xDEADBEEF), ext idle -> cpu_stall_o=1 in cycle 0; cpu_rdata_o=0xDEADBEEF and cpu_stall_o=0 in cycle 1.
REQ-030 CPU store 0x12345678 to 0x20 and ext write same cycle -> ram_we_o=1 with CPU data; ext_gnt_o=0; ext granted the next cycle.
REQ-031 CPU stores every cycle, ext_req_i held, STARVE_MAX=4 -> ext_gnt_o=1 on the 5th cycle, cpu_stall_o=1 in that cycle, starve_cnt=0 after.
REQ-032 CPU load and ext read alternate back-to-back -> each rvalid appears exactly 1 cycle after its grant with correct data; no response is duplicated.
REQ-033 rst_n pulsed low in the grant cycle of an ext read -> ext_rvalid_o stays 0; all outputs are 0 during reset.
REQ-034 ext_req_i dropped after 3 denied cycles, then reasserted -> starve_cnt restarts from 0; ext is not forced until 4 further denials.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port RAM between the pipeline
// memory stage (CPU) and an external loader/debug port. The CPU has priority,
// but an external requester that has been denied STARVE_MAX cycles in a row
// is forced through. Reads return one cycle after the grant.
module dmem_arbiter #(
  parameter int WIDTH      = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  // CPU side: request held until cpu_stall_o is low
  input  logic             cpu_req_i,
  input  logic             cpu_we_i,
  input  logic [WIDTH-1:0] cpu_adr_i,
  input  logic [WIDTH-1:0] cpu_wdata_i,
  output logic             cpu_stall_o,
  output logic [WIDTH-1:0] cpu_rdata_o,
  // External side
  input  logic             ext_req_i,
  input  logic             ext_we_i,
  input  logic [WIDTH-1:0] ext_adr_i,
  input  logic [WIDTH-1:0] ext_wdata_i,
  output logic             ext_gnt_o,
  output logic [WIDTH-1:0] ext_rdata_o,
  output logic             ext_rvalid_o,
  // RAM drive
  output logic [WIDTH-1:0] ram_adr_o,
  output logic [WIDTH-1:0] ram_wdata_o,
  output logic             ram_we_o,
  input  logic [WIDTH-1:0] ram_rdata_i,
  // Debug visibility of internal state
  output logic [1:0]       dbg_state_o,
  output logic [3:0]       dbg_starve_o
);

  // Handshake: the external port is valid/ready. ext_req_i (valid) may rise
  // or fall in any cycle; a transfer happens exactly in a cycle where
  // ext_req_i and ext_gnt_o (ready) are both high. ext_gnt_o is a
  // combinational function of the current request and internal state.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_RSP = 2'd1,
    EXT_RSP = 2'd2
  } state_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e           state_q, state_d;
  logic [3:0]       starve_q, starve_d;
  logic [WIDTH-1:0] cpu_rdata_q, ext_rdata_q;
  logic             cpu_elig, ext_force, cpu_gnt, ext_gnt;

  // Arbitration, RAM mux, stall and next-state logic
  always_comb begin
    // A CPU load already issued (CPU_RSP) must not be re-issued while held.
    cpu_elig  = cpu_req_i && (state_q != CPU_RSP);
    ext_force = ext_req_i && (starve_q == STARVE_LIM);
    ext_gnt   = rst_n && ext_req_i && (ext_force || !cpu_elig);
    cpu_gnt   = rst_n && cpu_elig && !ext_gnt;

    ram_adr_o   = '0;
    ram_wdata_o = '0;
    ram_we_o    = 1'b0;
    if (cpu_gnt) begin
      ram_adr_o   = cpu_adr_i;
      ram_wdata_o = cpu_wdata_i;
      ram_we_o    = cpu_we_i;
    end else if (ext_gnt) begin
      ram_adr_o   = ext_adr_i;
      ram_wdata_o = ext_wdata_i;
      ram_we_o    = ext_we_i;
    end

    cpu_stall_o = rst_n && cpu_req_i &&
                  !((cpu_gnt && cpu_we_i) || (state_q == CPU_RSP));

    starve_d = 4'd0;
    if (ext_req_i && !ext_gnt) begin
      starve_d = (starve_q >= STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;
    end

    state_d = IDLE;
    if (ext_gnt && !ext_we_i) begin
      state_d = EXT_RSP;
    end else if (cpu_gnt && !cpu_we_i) begin
      state_d = CPU_RSP;
    end
  end

  // State, starvation counter and read-data capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      starve_q    <= 4'd0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      if (cpu_gnt && !cpu_we_i) begin
        cpu_rdata_q <= ram_rdata_i;
      end
      if (ext_gnt && !ext_we_i) begin
        ext_rdata_q <= ram_rdata_i;
      end
    end
  end

  assign ext_gnt_o    = ext_gnt;
  assign cpu_rdata_o  = cpu_rdata_q;
  assign ext_rdata_o  = ext_rdata_q;
  assign ext_rvalid_o = (state_q == EXT_RSP);
  assign dbg_state_o  = state_q;
  assign dbg_starve_o = starve_q;

endmodule
